// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Drains a synchronous FIFO (registered read data, valid the cycle after an
//   accepted read) and packs `pack` consecutive words into one wide beat on a
//   valid/ready stream. A flush request closes a partially filled beat early.
//
// Ports:
//   clk           clock, rising edge
//   n_rst         asynchronous active-low reset
//   fifo_empty    FIFO isEmpty
//   fifo_rd_en    FIFO r_en
//   fifo_rd_data  FIFO r_data, valid the cycle after an accepted read
//   m_valid       output beat valid
//   m_ready       consumer accepts the beat
//   m_data        packed beat, oldest word in lane 0 (bits [d_width-1:0])
//   m_cnt         number of valid lanes in the beat (1..pack)
//   m_last        beat was closed by a flush
//   flush         single-cycle flush request
//   flush_busy    a flush is pending
//   beat_count    beats delivered, wraps modulo 2^16

module fifo_rd_packer #(
    parameter int d_width = 8,
    parameter int pack    = 4,
    parameter int cw      = $clog2(pack) + 1
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [d_width-1:0]        fifo_rd_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [d_width*pack-1:0]   m_data,
    output logic [cw-1:0]             m_cnt,
    output logic                      m_last,
    input  logic                      flush,
    output logic                      flush_busy,
    output logic [15:0]               beat_count
);

    localparam logic [cw-1:0] pack_c = cw'(pack);
    localparam logic [cw:0]   pack_s = (cw+1)'(pack);

    logic [d_width-1:0]      acc_reg [pack];
    logic [cw-1:0]           acc_cnt_reg;
    logic                    inflight_reg;
    logic                    flush_pend_reg;
    logic                    m_valid_reg;
    logic [d_width*pack-1:0] m_data_reg;
    logic [cw-1:0]           m_cnt_reg;
    logic                    m_last_reg;
    logic [15:0]             beat_count_reg;

    logic                    out_free;
    logic [cw:0]             fill_sum;
    logic                    acc_full;
    logic                    load_full;
    logic                    load_flush;
    logic                    flush_drop;
    logic                    load_beat;
    logic [d_width*pack-1:0] beat_next;

    // Lanes already in the accumulator plus the word landing this cycle.
    assign out_free   = !m_valid_reg || m_ready;
    assign fill_sum   = {1'b0, acc_cnt_reg} + {{cw{1'b0}}, inflight_reg};
    assign acc_full   = (fill_sum == pack_s);
    assign load_full  = acc_full && out_free;
    // A flush only closes the beat once nothing is in flight; a full
    // accumulator is handled by load_full instead (it also carries m_last).
    assign load_flush = flush_pend_reg && !inflight_reg && (acc_cnt_reg != '0)
                        && out_free && !acc_full;
    assign flush_drop = flush_pend_reg && !inflight_reg && (acc_cnt_reg == '0);
    assign load_beat  = load_full || load_flush;

    // The second term keeps one word per clock: the landing word completes
    // the beat, the beat leaves now, and the new read lands in lane 0.
    assign fifo_rd_en = n_rst && !fifo_empty && !flush_pend_reg &&
                        ((fill_sum < pack_s) || (acc_full && inflight_reg && out_free));

    // Beat assembly: captured lanes, then the landing word, zeros above.
    genvar gi;
    generate
        for (gi = 0; gi < pack; gi++) begin : g_lane
            assign beat_next[gi*d_width +: d_width] =
                (cw'(gi) < acc_cnt_reg)                  ? acc_reg[gi]  :
                (inflight_reg && cw'(gi) == acc_cnt_reg) ? fifo_rd_data :
                                                           '0;
        end
    endgenerate

    // Accumulator lanes: a landing word is stored unless it leaves directly
    // inside a beat this cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < pack; i++) acc_reg[i] <= '0;
        end else if (inflight_reg && !load_full) begin
            for (int i = 0; i < pack; i++) begin
                if (acc_cnt_reg == cw'(i)) acc_reg[i] <= fifo_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_cnt_reg    <= '0;
            inflight_reg   <= 1'b0;
            flush_pend_reg <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_cnt_reg      <= '0;
            m_last_reg     <= 1'b0;
            beat_count_reg <= '0;
        end else begin
            inflight_reg <= fifo_rd_en;

            // A new flush is only taken when none is pending.
            if (flush_pend_reg) begin
                if (load_beat || flush_drop) flush_pend_reg <= 1'b0;
            end else if (flush) begin
                flush_pend_reg <= 1'b1;
            end

            if (load_beat) begin
                acc_cnt_reg <= '0;
            end else if (inflight_reg) begin
                acc_cnt_reg <= acc_cnt_reg + cw'(1);
            end

            if (load_beat) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= beat_next;
                m_cnt_reg   <= load_full ? pack_c : acc_cnt_reg;
                m_last_reg  <= flush_pend_reg;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end

            if (m_valid_reg && m_ready) beat_count_reg <= beat_count_reg + 16'd1;
        end
    end

    assign m_valid    = m_valid_reg;
    assign m_data     = m_data_reg;
    assign m_cnt      = m_cnt_reg;
    assign m_last     = m_last_reg;
    assign flush_busy = flush_pend_reg;
    assign beat_count = beat_count_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer (d_width=8, pack=4). Contains a small FIFO
// model with registered read data and a beat monitor feeding a log.

module tb_fifo_rd_packer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [2:0]  m_cnt;
    logic        m_last;
    logic        flush = 1'b0;
    logic        flush_busy;
    logic [15:0] beat_count;

    int checks = 0;
    int errors = 0;

    fifo_rd_packer #(.d_width(8), .pack(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_cnt        (m_cnt),
        .m_last       (m_last),
        .flush        (flush),
        .flush_busy   (flush_busy),
        .beat_count   (beat_count)
    );

    always #5 clk = ~clk;

    // FIFO model: write pointer owned by the stimulus, read pointer by the model.
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr       <= wr_ptr;
            fifo_rd_data <= 8'h00;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Beat monitor: records every accepted beat.
    logic [31:0] log_data [0:63];
    logic [2:0]  log_cnt  [0:63];
    logic        log_last [0:63];
    int beat_wr = 0;
    int beat_rd = 0;

    always @(negedge clk) begin
        if (n_rst && m_valid && m_ready) begin
            log_data[beat_wr] = m_data;
            log_cnt[beat_wr]  = m_cnt;
            log_last[beat_wr] = m_last;
            $display("beat %0d: data=%08h cnt=%0d last=%0d", beat_wr, m_data, m_cnt, m_last);
            beat_wr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input string name, input logic [31:0] d,
                               input logic [2:0] c, input logic l);
        check({name, "_present"}, 64'(beat_wr > beat_rd), 64'd1);
        if (beat_wr > beat_rd) begin
            check({name, "_data"}, 64'(log_data[beat_rd]), 64'(d));
            check({name, "_cnt"},  64'(log_cnt[beat_rd]),  64'(c));
            check({name, "_last"}, 64'(log_last[beat_rd]), 64'(l));
            beat_rd++;
        end
    endtask

    task automatic no_more_beats(input string name);
        check(name, 64'(beat_wr - beat_rd), 64'd0);
    endtask

    // Pulse flush and count the cycles flush_busy is seen high.
    task automatic pulse_flush(output int busy);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (flush_busy) busy++;
            tick();
        end
    endtask

    typedef struct {
        int          n_words;
        logic [7:0]  base;
        logic [31:0] exp_data;
        logic [2:0]  exp_cnt;   // 0 means no beat expected
        logic        exp_last;
        int          exp_busy;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int run, maxrun, total, busy;
        logic [31:0] held;

        vecs[0] = '{3, 8'hA1, 32'h00A3A2A1, 3'd3, 1'b1, 1};
        vecs[1] = '{0, 8'h00, 32'h00000000, 3'd0, 1'b0, 1};
        vecs[2] = '{1, 8'hB1, 32'h000000B1, 3'd1, 1'b1, 1};
        vecs[3] = '{2, 8'hC1, 32'h0000C2C1, 3'd2, 1'b1, 1};

        // Reset state
        repeat (3) tick();
        check("rst_m_valid",    64'(m_valid), 64'd0);
        check("rst_m_data",     64'(m_data), 64'd0);
        check("rst_m_cnt",      64'(m_cnt), 64'd0);
        check("rst_m_last",     64'(m_last), 64'd0);
        check("rst_flush_busy", 64'(flush_busy), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_rd_en",      64'(fifo_rd_en), 64'd0);
        n_rst = 1'b1;
        tick();

        // Streaming at full rate
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        run = 0; maxrun = 0; total = 0;
        repeat (14) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                run++;
                total++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        tick();
        check("stream_rd_total", 64'(total), 64'd8);
        check("stream_rd_run",   64'(maxrun), 64'd8);
        expect_beat("stream_b0", 32'h14131211, 3'd4, 1'b0);
        expect_beat("stream_b1", 32'h18171615, 3'd4, 1'b0);
        no_more_beats("stream_extra");
        check("stream_beat_count", 64'(beat_count), 64'd2);

        // Backpressure: first beat held, accumulator fills, reads stall
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(8'h11 + 8'(i));
        repeat (6) tick();
        check("bp_valid_early", 64'(m_valid), 64'd1);
        held = m_data;
        check("bp_data_early", 64'(held), 64'h14131211);
        repeat (4) tick();
        check("bp_data_late", 64'(m_data), 64'h14131211);
        check("bp_cnt_late",  64'(m_cnt), 64'd4);
        check("bp_fifo_pending", 64'(fifo_empty), 64'd0);
        check("bp_rd_stalled", 64'(fifo_rd_en), 64'd0);
        no_more_beats("bp_none_while_stalled");
        m_ready = 1'b1;
        repeat (12) tick();
        expect_beat("bp_b0", 32'h14131211, 3'd4, 1'b0);
        expect_beat("bp_b1", 32'h18171615, 3'd4, 1'b0);
        no_more_beats("bp_extra");
        pulse_flush(busy);
        expect_beat("bp_tail", 32'h00000019, 3'd1, 1'b1);
        check("bp_beat_count", 64'(beat_count), 64'd5);

        // Flush table: partial beats and the empty flush
        for (int v = 0; v < 4; v++) begin
            for (int w = 0; w < vecs[v].n_words; w++) push(vecs[v].base + 8'(w));
            repeat (8) tick();
            no_more_beats($sformatf("vec%0d_prefl", v));
            pulse_flush(busy);
            check($sformatf("vec%0d_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
            if (vecs[v].exp_cnt == 3'd0)
                no_more_beats($sformatf("vec%0d_nobeat", v));
            else
                expect_beat($sformatf("vec%0d", v), vecs[v].exp_data,
                            vecs[v].exp_cnt, vecs[v].exp_last);
        end
        check("tbl_beat_count", 64'(beat_count), 64'd8);

        // Flush in the cycle the 4th read issues
        for (int i = 0; i < 4; i++) push(8'hD1 + 8'(i));
        repeat (3) tick();
        check("f4_rd_issue", 64'(fifo_rd_en), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (10) tick();
        expect_beat("f4_beat", 32'hD4D3D2D1, 3'd4, 1'b1);
        no_more_beats("f4_extra");
        check("f4_busy_clear", 64'(flush_busy), 64'd0);
        check("f4_beat_count", 64'(beat_count), 64'd9);

        // Reset mid-beat (two lanes captured, one word in flight)
        for (int i = 0; i < 4; i++) push(8'hE1 + 8'(i));
        repeat (3) tick();
        no_more_beats("mid_none");
        n_rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_data",  64'(m_data), 64'd0);
        check("mid_rst_cnt",   64'(m_cnt), 64'd0);
        check("mid_rst_count", 64'(beat_count), 64'd0);
        check("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(8'hF1 + 8'(i));
        repeat (10) tick();
        expect_beat("post_rst", 32'hF4F3F2F1, 3'd4, 1'b0);
        no_more_beats("post_rst_extra");
        check("post_rst_count", 64'(beat_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side stage that sits directly downstream of the team's synchronous FIFO and drains it through its r_en / r_data / isEmpty interface.
- Packs `pack` consecutive FIFO words into one wide output beat.
- Presents the beat on a valid/ready stream interface.
- Supports a flush request that emits a partial beat, so the consumer never waits on a trickle of words.

Parameters:
- d_width, 8: width of one FIFO word.
- pack, 4: FIFO words per output beat; legal range 2..16.
- cw, $clog2(pack)+1: width of the lane-count field (derived; not to be overridden).

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO isEmpty.
- fifo_rd_en  output  1  FIFO r_en.
- fifo_rd_data  input  d_width  FIFO r_data. Registered in the FIFO; valid the cycle after an accepted read.
- m_valid  output  1  output beat valid.
- m_ready  input  1  consumer accepts the beat.
- m_data  output  d_width*pack  packed beat. The oldest word is in lane 0, bits [d_width-1:0].
- m_cnt  output  cw  number of valid lanes in the beat (1..pack).
- m_last  output  1  the beat was closed by a flush.
- flush  input  1  single-cycle flush request.
- flush_busy  output  1  a flush is pending.
- beat_count  output  16  beats delivered; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous, n_rst=0):
  - m_valid, m_data, m_cnt, m_last, flush_busy, beat_count and fifo_rd_en are all 0.
  - Internal state is cleared: acc_cnt=0, inflight=0, flush_pend=0.
  - Reset mid-operation discards any in-flight word and any partially packed lanes. The FIFO is reset by the same n_rst.
- FIFO read timing:
  - A read is accepted in cycle N when fifo_rd_en=1 and fifo_empty=0.
  - inflight is set for cycle N+1; the word is captured from fifo_rd_data at the end of N+1.
- Accumulator:
  - acc_cnt (0..pack) counts captured lanes. A landing word goes to lane acc_cnt.
  - out_free = !m_valid || m_ready.
- Read issue (combinational; depends on m_ready):
  - fifo_rd_en = !fifo_empty && !flush_pend && (acc_cnt+inflight < pack || (acc_cnt+inflight == pack && inflight && out_free)).
  - The second term sustains 1 word/clk. The landing word completes the beat, the beat leaves this cycle, and the new read lands into lane 0.
- Beat transfer:
  - Triggered when the accumulator becomes full (acc_cnt+landing == pack) and out_free.
  - Output register loads {landing word, acc lanes}, m_cnt=pack, m_valid=1, acc_cnt←0, all in the same cycle.
  - If the output is not free, the accumulator holds its full state and no reads issue until the output drains.
- Output hold:
  - While m_valid && !m_ready, m_data, m_cnt and m_last stay stable.
  - On m_valid && m_ready with no new beat loading, m_valid←0.
- Flush sequence:
  - flush=1 sets flush_pend (flush_busy) next cycle. A flush asserted while one is already pending is ignored.
  - While pending, no new reads issue, and the block waits for inflight=0.
  - If acc_cnt=0, flush_pend clears and no beat is emitted.
  - Otherwise, when out_free, the block emits a beat with m_cnt=acc_cnt and m_last=1; unused upper lanes are zero. acc_cnt←0 and flush_pend clears.
  - If the in-flight word fills the accumulator during a pending flush, the full beat carries m_last=1 and clears flush_pend.
- Lane and counter rules:
  - Non-flush beats always carry m_cnt=pack and m_last=0.
  - beat_count increments on every m_valid && m_ready and wraps from 0xFFFF to 0.
- Empty FIFO: fifo_rd_en=0. Partial lanes are retained indefinitely until more data arrives or a flush is requested.

Test Plan:
1. Reset, then preload FIFO with 0x11..0x18 and hold m_ready=1 -> beats 0x14131211 then 0x18171615, each with m_cnt=4 and m_last=0. fifo_rd_en stays high 8 consecutive clocks; beat_count=2.
2. Same data with m_ready=0 for 10 clocks -> first beat is held stable. A second full accumulator stalls and fifo_rd_en=0. Releasing m_ready delivers both beats in order with no loss or duplication.
3. Write 0xA1,0xA2,0xA3, then pulse flush -> one beat 0x00A3A2A1 with m_cnt=3 and m_last=1. flush_busy is high until that beat loads.
4. Pulse flush with the FIFO and accumulator empty -> no beat; flush_busy is high for exactly one cycle.
5. Write 4 words and pulse flush in the cycle the 4th read is issued -> a single beat with m_cnt=4 and m_last=1; no extra empty beat.
6. Assert n_rst=0 mid-beat (acc_cnt=2, inflight=1) -> all outputs 0 immediately. After release, a fresh 4-word stream packs from lane 0.
